param_register_file: RTL
========================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NUM_REGS, default 32: number of registers; SHALL be a power of two, >= 4; IDX_W = log2(NUM_REGS).
REQ-003 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-004 Parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 write_enable  input  1  commit write_data this edge.
REQ-009 write_register  input  IDX_W  write destination index.
REQ-010 write_data  input  DATA_WIDTH  write value.
REQ-011 write_byte_enable  input  DATA_WIDTH/8  per-byte write lane mask; bit k covers bits [8k+7:8k].
REQ-012 reserve_enable  input  1  mark reserve_register pending (multi-cycle load issued).
REQ-013 reserve_register  input  IDX_W  index to mark pending.
REQ-014 register_a_index, register_b_index  input  IDX_W  read port indices.
REQ-015 register_a_data, register_b_data  output  DATA_WIDTH  read port data.
REQ-016 register_a_busy, register_b_busy  output  1  read register has a pending write.
REQ-017 v0  output  DATA_WIDTH  stored contents of register 2, no forwarding.

Function
REQ-018 Storage: NUM_REGS x DATA_WIDTH flops plus a NUM_REGS-bit busy vector.
REQ-019 Write: on rising clk with write_enable=1 and reset=0, only lanes with write_byte_enable set update; other lanes keep old value.
REQ-020 ZERO_REG=1: writes and reserves to index 0 ignored; reads of index 0 return 0 and busy 0.
REQ-021 Reads combinational: data = stored[index], zero-latency.
REQ-022 BYPASS=1: if write_enable=1, reset=0, write_register == read index (nonzero when ZERO_REG=1), read data = byte-merge of write_data over stored value per write_byte_enable, same cycle.
REQ-023 BYPASS=0: same-cycle read returns old value; new value visible the cycle after the edge.
REQ-024 Both read ports independent; same index on both ports returns identical data and busy.
REQ-025 Busy set: reserve_enable=1 at edge sets busy[reserve_register].
REQ-026 Busy clear: write_enable=1 at edge clears busy[write_register] regardless of byte mask.
REQ-027 Reserve and write to same index same edge: reserve wins, busy ends 1, data still written.
REQ-028 Reserve of already-busy register: stays 1 (no counting); write to non-busy register: busy stays 0.
REQ-029 busy output = busy[index]; with BYPASS=1, cleared combinationally by a same-cycle forwarding write hit.
REQ-030 v0 reflects stored register 2 only; updates the cycle after a write to index 2.

Reset
REQ-031 reset=1 at rising clk: all registers and all busy bits become 0 after that edge.
REQ-032 Reset has priority: write_enable and reserve_enable ignored on any edge where reset=1.
REQ-033 While reset=1, forwarding suppressed; reads return stored values until the reset edge, 0 after.
REQ-034 Post-reset outputs: all read data 0, all busy 0, v0 = 0.
REQ-035 Reset asserted mid-sequence (busy bits set, writes in flight) SHALL leave no residual state after one reset edge.

Verification
REQ-036 Reset, then write r5=0xDEADBEEF mask 1111, read a=5 next cycle -> 0xDEADBEEF; v0=0.
REQ-037 r7=0x11223344, write 0xAABBCCDD mask 0101 -> r7=0x11BB33DD; BYPASS=1 same-cycle read a=7 -> 0x11BB33DD; BYPASS=0 -> 0x11223344 then 0x11BB33DD.
REQ-038 Write r0=0xFFFFFFFF and reserve r0 -> read r0 returns 0, busy 0 (ZERO_REG=1).
REQ-039 Reserve r9 -> busy_a(9)=1 next cycle; write r9=0x5 -> busy 0 after edge (0 same cycle with BYPASS=1); simultaneous reserve+write r9 -> busy 1, data 0x5.
REQ-040 Write r2=0x12345678 with reset=1 same edge -> r2=0, v0=0, no forwarding seen; write without reset -> v0=0x12345678 next cycle.
REQ-041 Re-run REQ-036..040 at DATA_WIDTH=64, NUM_REGS=16: index wrap limited to 0..15, 8-lane masks honoured.

Source files
------------

// File: rtl/param_register_file.sv
// Parameterised register file: two combinational read ports, one byte-masked write port,
// per-register busy (pending load) tracking, optional write-to-read forwarding and hardwired zero register.
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int NUM_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [IDX_W-1:0]      write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [NUM_BYTES-1:0]  write_byte_enable,
  input  logic                  reserve_enable,
  input  logic [IDX_W-1:0]      reserve_register,
  input  logic [IDX_W-1:0]      register_a_index,
  input  logic [IDX_W-1:0]      register_b_index,
  output logic [DATA_WIDTH-1:0] register_a_data,
  output logic [DATA_WIDTH-1:0] register_b_data,
  output logic                  register_a_busy,
  output logic                  register_b_busy,
  output logic [DATA_WIDTH-1:0] v0
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  logic                  write_commit;
  logic                  reserve_commit;
  logic [DATA_WIDTH-1:0] merged_write;

  logic [IDX_W-1:0]      rd_index [2];
  logic [DATA_WIDTH-1:0] rd_data  [2];
  logic                  rd_busy  [2];

  // Writes and reserves aimed at a hardwired-zero register 0 are dropped here.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    merged_write   = regs[write_register];
    write_commit   = write_enable && !reset && !(ZERO_REG != 0 && write_register == '0);
    reserve_commit = reserve_enable && !(ZERO_REG != 0 && reserve_register == '0);
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (write_byte_enable[k]) merged_write[8*k +: 8] = write_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage array is reset explicitly; no residual state may survive a reset edge.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (write_commit) begin
        regs[write_register] <= merged_write;
        busy[write_register] <= 1'b0;
      end
      // NOTE: non-blocking assignments resolve last-wins, so a same-edge reserve overrides the write's busy clear.
      if (reserve_commit) busy[reserve_register] <= 1'b1;
    end
  end

  assign rd_index[0] = register_a_index;
  assign rd_index[1] = register_b_index;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_index[p]];
      rd_busy[p] = busy[rd_index[p]];
      if (BYPASS != 0 && write_commit && write_register == rd_index[p]) begin
        rd_data[p] = merged_write;
        rd_busy[p] = 1'b0;
      end
      if (ZERO_REG != 0 && rd_index[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign register_a_data = rd_data[0];
  assign register_b_data = rd_data[1];
  assign register_a_busy = rd_busy[0];
  assign register_b_busy = rd_busy[1];
  assign v0              = regs[2];

endmodule
